hdlc_rx_ctrl: RTL and testbench
===============================

# hdlc_rx_ctrl

- Serial HDLC-style receive controller.
- Drives a Mealy flag detector for the 01111110 flag and sequences frame reception.
- Strips zero-stuffing, assembles LSB-first bytes, and reports frame boundaries, aborts and errors.
- Sits between the serial line sampler and the byte-level frame consumer.

## Interface
- MAX_BYTES, 64, maximum data bytes per frame; byte counter width is $clog2(MAX_BYTES+1).
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- serIn  in  1  serial line bit, sampled every clk while en=1.
- en  in  1  receive enable; low forces IDLE.
- byte_out  out  8  last assembled data byte; holds between strobes.
- byte_valid  out  1  one-cycle strobe, byte_out is new.
- frame_start  out  1  one-cycle strobe, coincides with the first byte_valid of a frame.
- frame_end  out  1  one-cycle strobe, good frame closed.
- frame_err  out  1  one-cycle strobe, current frame discarded; the consumer drops all of its bytes.

## Operation
- Reset: state=IDLE, counters 0, byte_out=8'h00, all strobes 0.
- States:
  - IDLE: en=0.
  - HUNT: waits for a flag.
  - RECV: receiving data.
- IDLE→HUNT when en=1.
- HUNT→RECV on w_detect=1. Counters clear: bit_cnt, ones_cnt, byte_cnt.
- en=0 in any state → IDLE next cycle. If RECV with byte_cnt>0, frame_err pulses once.
- RECV, per sampled bit, in priority order:
  1. w_detect=1 (flag's final 0), closing rule:
     - bit_cnt==7 and byte_cnt>0 → frame_end.
     - bit_cnt==7 and byte_cnt==0 → idle/back-to-back flag, no strobe.
     - Otherwise → frame_err (misaligned).
     - In all three cases, clear counters and stay in RECV; the closing flag is shared as the opening flag.
  2. ones_cnt==6 and serIn=1 → abort. frame_err only if byte_cnt>0, then go to HUNT.
  3. ones_cnt==5 and serIn=0 → stuff bit dropped, no shift, ones_cnt=0.
  4. Otherwise data bit:
     - Shift into an 8-bit register from the MSB side (LSB-first line order).
     - bit_cnt+1 mod 8.
     - ones_cnt = serIn ? ones_cnt+1 : 0.
     - On bit_cnt wrap 7→0, a byte completes:
       - byte_cnt<MAX_BYTES → byte_valid, byte_cnt+1.
       - Otherwise → overflow: frame_err, no byte_valid, go to HUNT.
- The 7 bits 0111111 of a closing flag enter the shifter as data. This is why bit_cnt==7 marks alignment. These bits never complete a byte in an aligned frame.
- Misaligned frames may emit one spurious byte before frame_err. This is legal; frame_err invalidates it.

## Timing
- The detector is instantiated with en passed through. w_detect is combinational on serIn and is used in the same cycle.
- All outputs are registered. Latency is 1 clk from the sampling edge of the deciding bit:
  - byte_valid: after the 8th data bit.
  - frame_end / frame_err: after the flag's final 0, the abort bit, or the overflow bit.
- frame_end and byte_valid never coincide; the last byte precedes frame_end by ≥8 cycles.
- Simultaneous rst and en → rst wins.
- rst mid-frame → IDLE, no strobes.

## Configuration
- HDLC_RX_STATS_EN defined:
  - Adds output good_cnt (16 bits): counts frame_end, wraps.
  - Adds output err_cnt (8 bits): counts frame_err, saturates at 8'hFF.
  - Both counters clear on rst only, not on en=0.
- HDLC_RX_STATS_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Package hdlc_pkg holds:
  - State enum: IDLE, HUNT, RECV.
  - HDLC_FLAG = 8'h7E.
  - STUFF_RUN = 5.
  - ABORT_RUN = 7.
- Sub-module hdlc_flag_detect:
  - Seven-state Mealy detector with ports clk, rst, serIn, en, w_detect.
  - Resets to its start state on rst or en=0.
  - w_detect = serIn==0 in its last state.

## Test plan
- Good single byte: en=1; line sends 7E, A5 (1,0,1,0,0,1,0,1), 7E → byte_valid with byte_out=8'hA5 plus frame_start, 1 clk after the 8th data bit; frame_end 1 clk after the final 0 of the second flag; no frame_err.
- Stuffing: 7E, then 1,1,1,1,1,0,1,1,1, then 7E → exactly one byte 8'hFF, frame_end, stuff 0 dropped.
- Back-to-back flags: 7E,7E,7E, then 3C, 7E → no strobes for the empty flags; one byte 8'h3C, frame_end.
- Abort / misalign: 7E, A5, then seven 1s → frame_err, HUNT. Separately: 7E, A5, 3 extra bits, 7E → frame_err.
- Overflow: MAX_BYTES=4; 7E, five bytes 11 22 33 44 55 → four byte_valid, frame_err on the 5th byte, no frame_end, returns to HUNT.
- en drop / rst: deassert en after 2 bytes → frame_err once, IDLE. rst during RECV → all outputs 0, no strobe. With HDLC_RX_STATS_EN: good_cnt and err_cnt match the strobe counts.

Source files
------------

// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared types and constants for the HDLC receive controller slice.
package hdlc_pkg;

   // Receive controller states
   typedef enum logic [1:0] {
      IDLE,
      HUNT,
      RECV
   } rx_state_t;

   // Flag detector states: FD_ONEn means "a 0 followed by n ones"
   typedef enum logic [2:0] {
      FD_ZERO,
      FD_ONE1,
      FD_ONE2,
      FD_ONE3,
      FD_ONE4,
      FD_ONE5,
      FD_ONE6
   } fd_state_t;

   localparam logic [7:0] HDLC_FLAG = 8'h7E;
   localparam int         STUFF_RUN = 5;
   localparam int         ABORT_RUN = 7;

endpackage

// File: rtl/hdlc_flag_detect.sv
// hdlc_flag_detect: seven-state Mealy detector for the 01111110 flag.
// w_detect is combinational and fires on the flag's final 0.
// The start state also stands for "previous bit was 0", so a flag is
// recognised straight after reset or enable.
module hdlc_flag_detect
   import hdlc_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic serIn,
   input  logic en,
   output logic w_detect
);

   fd_state_t state;
   fd_state_t state_nxt;

   // State register; disabled receiver holds the detector at its start state
   always_ff @(posedge clk) begin
      if (rst || !en) state <= FD_ZERO;
      else            state <= state_nxt;
   end

   // Next state and Mealy detect output; a seventh 1 in a row falls back to start
   always_comb begin
      state_nxt = FD_ZERO;
      w_detect  = (state == FD_ONE6) && (serIn == HDLC_FLAG[7]);
      if (serIn) begin
         case (state)
            FD_ZERO: state_nxt = FD_ONE1;
            FD_ONE1: state_nxt = FD_ONE2;
            FD_ONE2: state_nxt = FD_ONE3;
            FD_ONE3: state_nxt = FD_ONE4;
            FD_ONE4: state_nxt = FD_ONE5;
            FD_ONE5: state_nxt = FD_ONE6;
            default: state_nxt = FD_ZERO;
         endcase
      end
   end

endmodule

// File: rtl/hdlc_rx_ctrl.sv
// hdlc_rx_ctrl: HDLC receive controller. Removes zero-stuffing, assembles
// LSB-first bytes and strobes frame start/end/error.
// Optional feature macro HDLC_RX_STATS_EN adds good_cnt/err_cnt outputs.
module hdlc_rx_ctrl
   import hdlc_pkg::*;
#(
   parameter int MAX_BYTES = 64
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        serIn,
   input  logic        en,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        frame_start,
   output logic        frame_end,
   output logic        frame_err
`ifdef HDLC_RX_STATS_EN
   ,
   output logic [15:0] good_cnt,
   output logic [7:0]  err_cnt
`endif
);

   localparam int              CW      = $clog2(MAX_BYTES + 1);
   localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BYTES);

   rx_state_t     state, state_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [2:0]    ones_cnt, ones_cnt_nxt;
   logic [CW-1:0] byte_cnt, byte_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [7:0]    byte_out_nxt;
   logic          byte_valid_nxt, frame_start_nxt, frame_end_nxt, frame_err_nxt;
   logic          w_detect;

   hdlc_flag_detect u_flag_detect (
      .clk      (clk),
      .rst      (rst),
      .serIn    (serIn),
      .en       (en),
      .w_detect (w_detect)
   );

   // Register state, datapath and the strobes so every output is registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         ones_cnt    <= '0;
         byte_cnt    <= '0;
         shreg       <= '0;
         byte_out    <= 8'h00;
         byte_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         ones_cnt    <= ones_cnt_nxt;
         byte_cnt    <= byte_cnt_nxt;
         shreg       <= shreg_nxt;
         byte_out    <= byte_out_nxt;
         byte_valid  <= byte_valid_nxt;
         frame_start <= frame_start_nxt;
         frame_end   <= frame_end_nxt;
         frame_err   <= frame_err_nxt;
      end
   end

   // Per-bit decision: flag close, abort, stuff removal, then ordinary data
   always_comb begin
      state_nxt       = state;
      bit_cnt_nxt     = bit_cnt;
      ones_cnt_nxt    = ones_cnt;
      byte_cnt_nxt    = byte_cnt;
      shreg_nxt       = shreg;
      byte_out_nxt    = byte_out;
      byte_valid_nxt  = 1'b0;
      frame_start_nxt = 1'b0;
      frame_end_nxt   = 1'b0;
      frame_err_nxt   = 1'b0;

      if (!en) begin
         state_nxt     = IDLE;
         frame_err_nxt = (state == RECV) && (byte_cnt != '0);
      end else begin
         case (state)
            IDLE: state_nxt = HUNT;
            HUNT: begin
               if (w_detect) begin
                  state_nxt    = RECV;
                  bit_cnt_nxt  = '0;
                  ones_cnt_nxt = '0;
                  byte_cnt_nxt = '0;
               end
            end
            RECV: begin
               if (w_detect) begin
                  if (bit_cnt == 3'd7) frame_end_nxt = (byte_cnt != '0);
                  else                 frame_err_nxt = 1'b1;
                  bit_cnt_nxt  = '0;
                  ones_cnt_nxt = '0;
                  byte_cnt_nxt = '0;
               end else if (serIn && (ones_cnt == 3'(ABORT_RUN - 1))) begin
                  frame_err_nxt = (byte_cnt != '0);
                  state_nxt     = HUNT;
               end else if (!serIn && (ones_cnt == 3'(STUFF_RUN))) begin
                  ones_cnt_nxt = '0;
               end else begin
                  shreg_nxt    = {serIn, shreg[7:1]};
                  bit_cnt_nxt  = bit_cnt + 3'd1;
                  ones_cnt_nxt = serIn ? (ones_cnt + 3'd1) : 3'd0;
                  if (bit_cnt == 3'd7) begin
                     if (byte_cnt < MAX_CNT) begin
                        byte_valid_nxt  = 1'b1;
                        frame_start_nxt = (byte_cnt == '0);
                        byte_out_nxt    = shreg_nxt;
                        byte_cnt_nxt    = byte_cnt + 1'b1;
                     end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = HUNT;
                     end
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef HDLC_RX_STATS_EN
   // Frame statistics: good frames wrap, errors saturate; only rst clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         good_cnt <= '0;
         err_cnt  <= '0;
      end else begin
         if (frame_end)                    good_cnt <= good_cnt + 16'd1;
         if (frame_err && err_cnt != 8'hFF) err_cnt  <= err_cnt + 8'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// tb_hdlc_rx_ctrl: directed self-checking bench for hdlc_rx_ctrl (MAX_BYTES=4).
module tb_hdlc_rx_ctrl;

   localparam int MAX_B = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       serIn;
   logic       en;
   logic [7:0] byte_out;
   logic       byte_valid, frame_start, frame_end, frame_err;
`ifdef HDLC_RX_STATS_EN
   logic [15:0] good_cnt;
   logic [7:0]  err_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int n_bv, n_fs, n_fe, n_err;
   logic [7:0] got_bytes[$];

   hdlc_rx_ctrl #(.MAX_BYTES(MAX_B)) dut (
      .clk         (clk),
      .rst         (rst),
      .serIn       (serIn),
      .en          (en),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .frame_err   (frame_err)
`ifdef HDLC_RX_STATS_EN
      ,
      .good_cnt    (good_cnt),
      .err_cnt     (err_cnt)
`endif
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock, sample 1 time unit after the edge and tally strobes
   task automatic tick();
      @(posedge clk);
      #1;
      if (byte_valid) begin
         n_bv++;
         got_bytes.push_back(byte_out);
      end
      if (frame_start) n_fs++;
      if (frame_end)   n_fe++;
      if (frame_err)   n_err++;
   endtask

   task automatic send_bit(input logic b);
      serIn = b;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic clear_mon();
      n_bv = 0; n_fs = 0; n_fe = 0; n_err = 0;
      got_bytes.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; serIn = 1'b1;
      tick(); tick();
      rst = 1'b0;
      clear_mon();
   endtask

   // Enable and idle two 1s so the controller reaches HUNT
   task automatic start_rx();
      en = 1'b1;
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; serIn = 1'b0;
      tick(); tick();
      tests_run++;
      if ({byte_out, byte_valid, frame_start, frame_end, frame_err} !== 12'h000) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %h expected 000",
                  {byte_out, byte_valid, frame_start, frame_end, frame_err});
      end
      rst = 1'b0; en = 1'b0;
   endtask

   task automatic test_single_byte();
      logic [7:0] d = 8'hA5;
      logic [7:0] f = 8'h7E;
      do_reset(); start_rx();
      send_byte(8'h7E);
      tests_run++;
      if (n_bv + n_fe + n_err !== 0) begin
         tests_failed++; $display("[TB] FAIL open_flag_quiet: got %0d strobes expected 0", n_bv + n_fe + n_err);
      end
      for (int i = 0; i < 7; i++) send_bit(d[i]);
      tests_run++;
      if (byte_valid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL bv_early: got %b expected 0", byte_valid);
      end
      send_bit(d[7]);
      tests_run++;
      if ({byte_valid, frame_start, byte_out} !== {2'b11, 8'hA5}) begin
         tests_failed++; $display("[TB] FAIL single_byte: got bv=%b fs=%b byte=%h expected bv=1 fs=1 byte=a5",
                                  byte_valid, frame_start, byte_out);
      end
      for (int i = 0; i < 7; i++) send_bit(f[i]);
      tests_run++;
      if (frame_end !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL fe_early: got %b expected 0", frame_end);
      end
      send_bit(f[7]);
      tests_run++;
      if ({frame_end, frame_err, byte_valid} !== 3'b100) begin
         tests_failed++; $display("[TB] FAIL single_frame_end: got fe/ferr/bv=%b expected 100",
                                  {frame_end, frame_err, byte_valid});
      end
      send_bit(1'b1);
      tests_run++;
      if ({frame_end, n_bv, n_err} !== {1'b0, 32'd1, 32'd0}) begin
         tests_failed++; $display("[TB] FAIL single_after: got fe=%b bytes=%0d errs=%0d expected fe=0 bytes=1 errs=0",
                                  frame_end, n_bv, n_err);
      end
   endtask

   task automatic test_stuffing();
      logic [8:0] s = 9'b111011111;
      do_reset(); start_rx();
      send_byte(8'h7E);
      for (int i = 0; i < 8; i++) send_bit(s[i]);
      tests_run++;
      if (byte_valid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL stuff_not_dropped: got bv=%b expected 0", byte_valid);
      end
      send_bit(s[8]);
      tests_run++;
      if ({byte_valid, byte_out} !== {1'b1, 8'hFF}) begin
         tests_failed++; $display("[TB] FAIL stuff_byte: got bv=%b byte=%h expected bv=1 byte=ff", byte_valid, byte_out);
      end
      send_byte(8'h7E);
      tick();
      tests_run++;
      if ({n_bv, n_fe, n_err} !== {32'd1, 32'd1, 32'd0}) begin
         tests_failed++; $display("[TB] FAIL stuff_counts: got bytes=%0d ends=%0d errs=%0d expected 1 1 0", n_bv, n_fe, n_err);
      end
   endtask

   task automatic test_back_to_back();
      do_reset(); start_rx();
      send_byte(8'h7E); send_byte(8'h7E); send_byte(8'h7E);
      tests_run++;
      if (n_bv + n_fs + n_fe + n_err !== 0) begin
         tests_failed++; $display("[TB] FAIL empty_flags: got %0d strobes expected 0", n_bv + n_fs + n_fe + n_err);
      end
      send_byte(8'h3C); send_byte(8'h7E);
      tick();
      tests_run++;
      if ({n_bv, n_fs, n_fe, n_err} !== {32'd1, 32'd1, 32'd1, 32'd0} || got_bytes[0] !== 8'h3C) begin
         tests_failed++; $display("[TB] FAIL b2b_frame: got bytes=%0d starts=%0d ends=%0d errs=%0d b0=%h expected 1 1 1 0 3c",
                                  n_bv, n_fs, n_fe, n_err, got_bytes[0]);
      end
   endtask

   task automatic test_abort();
      int err_idx = -1;
      do_reset(); start_rx();
      send_byte(8'h7E); send_byte(8'hA5);
      // A5 ends with a 1, so the sixth extra 1 completes a run of seven
      for (int i = 0; i < 7; i++) begin
         send_bit(1'b1);
         if (frame_err && err_idx < 0) err_idx = i;
      end
      tests_run++;
      if (err_idx !== 5 || n_err !== 1 || n_fe !== 0) begin
         tests_failed++; $display("[TB] FAIL abort: got err_at=%0d errs=%0d ends=%0d expected 5 1 0", err_idx, n_err, n_fe);
      end
      send_byte(8'h3C);
      tests_run++;
      if (n_bv !== 1) begin
         tests_failed++; $display("[TB] FAIL abort_hunt: got bytes=%0d expected 1", n_bv);
      end
      send_byte(8'h7E); send_byte(8'h66); send_byte(8'h7E);
      tick();
      tests_run++;
      if ({n_bv, n_fe} !== {32'd2, 32'd1} || got_bytes[1] !== 8'h66) begin
         tests_failed++; $display("[TB] FAIL abort_recover: got bytes=%0d ends=%0d b1=%h expected 2 1 66", n_bv, n_fe, got_bytes[1]);
      end
   endtask

   task automatic test_misalign();
      logic [7:0] f = 8'h7E;
      do_reset(); start_rx();
      send_byte(8'h7E); send_byte(8'hA5);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(f[i]);
      tests_run++;
      if (n_err !== 0) begin
         tests_failed++; $display("[TB] FAIL misalign_early: got errs=%0d expected 0", n_err);
      end
      send_bit(f[7]);
      tests_run++;
      if ({frame_err, frame_end} !== 2'b10 || n_fe !== 0) begin
         tests_failed++; $display("[TB] FAIL misalign: got ferr=%b fe=%b ends=%0d expected 1 0 0", frame_err, frame_end, n_fe);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] v = 8'h55;
      logic [7:0] exp_b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset(); start_rx();
      send_byte(8'h7E);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (got_bytes.size() <= i || got_bytes[i] !== exp_b[i]) begin
            tests_failed++; $display("[TB] FAIL ovf_byte%0d: got count=%0d expected %h", i, got_bytes.size(), exp_b[i]);
         end
      end
      for (int i = 0; i < 7; i++) send_bit(v[i]);
      send_bit(v[7]);
      tests_run++;
      if ({frame_err, byte_valid} !== 2'b10 || n_bv !== 4 || n_fe !== 0) begin
         tests_failed++; $display("[TB] FAIL overflow: got ferr=%b bv=%b bytes=%0d ends=%0d expected 1 0 4 0",
                                  frame_err, byte_valid, n_bv, n_fe);
      end
      send_byte(8'h7E); send_byte(8'h66); send_byte(8'h7E);
      tick();
      tests_run++;
      if ({n_bv, n_fs, n_fe, n_err} !== {32'd5, 32'd2, 32'd1, 32'd1} || got_bytes[4] !== 8'h66) begin
         tests_failed++; $display("[TB] FAIL ovf_recover: got bytes=%0d starts=%0d ends=%0d errs=%0d expected 5 2 1 1",
                                  n_bv, n_fs, n_fe, n_err);
      end
   endtask

   task automatic test_en_drop();
      do_reset(); start_rx();
      send_byte(8'h7E); send_byte(8'hA5); send_byte(8'h3C);
      en = 1'b0;
      tick();
      tests_run++;
      if (frame_err !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL en_drop_err: got %b expected 1", frame_err);
      end
      tick();
      tests_run++;
      if (frame_err !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL en_drop_once: got %b expected 0", frame_err);
      end
      send_byte(8'h7E); send_byte(8'h7E);
      tests_run++;
      if ({n_bv, n_fe, n_err} !== {32'd2, 32'd0, 32'd1}) begin
         tests_failed++; $display("[TB] FAIL en_drop_idle: got bytes=%0d ends=%0d errs=%0d expected 2 0 1", n_bv, n_fe, n_err);
      end
   endtask

   task automatic test_rst_mid_frame();
      do_reset(); start_rx();
      send_byte(8'h7E); send_byte(8'hA5);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      clear_mon();
      rst = 1'b1;
      tick(); tick();
      tests_run++;
      if ({byte_out, byte_valid, frame_start, frame_end, frame_err} !== 12'h000 || n_fe + n_err + n_bv !== 0) begin
         tests_failed++; $display("[TB] FAIL rst_mid: got outs=%h strobes=%0d expected 000 0",
                                  {byte_out, byte_valid, frame_start, frame_end, frame_err}, n_fe + n_err + n_bv);
      end
      rst = 1'b0;
      send_byte(8'h3C);
      tests_run++;
      if (n_bv + n_fs + n_fe + n_err !== 0) begin
         tests_failed++; $display("[TB] FAIL rst_after: got %0d strobes expected 0", n_bv + n_fs + n_fe + n_err);
      end
   endtask

`ifdef HDLC_RX_STATS_EN
   task automatic test_stats();
      do_reset(); start_rx();
      send_byte(8'h7E); send_byte(8'hA5); send_byte(8'h7E);
      send_byte(8'hA5);
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      en = 1'b0;
      tick(); tick();
      en = 1'b1;
      tick(); tick();
      tests_run++;
      if ({good_cnt, err_cnt} !== {16'd1, 8'd1}) begin
         tests_failed++; $display("[TB] FAIL stats: got good=%0d err=%0d expected 1 1", good_cnt, err_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; en = 1'b0; serIn = 1'b1;
      clear_mon();
      test_reset();
      test_single_byte();
      test_stuffing();
      test_back_to_back();
      test_abort();
      test_misalign();
      test_overflow();
      test_en_drop();
      test_rst_mid_frame();
`ifdef HDLC_RX_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
